// File: rtl/wide_add_pkg.sv
// Shared definitions for the multi-word add sequencer.
package wide_add_pkg;

    localparam int WORD_W        = 32;
    localparam int MAX_WORDS_DEF = 8;

    typedef enum logic {
        WA_IDLE = 1'b0,
        WA_RUN  = 1'b1
    } wa_state_e;

endpackage

// File: rtl/wide_add_seq_cla.sv
// CLA: 32-bit purely combinational carry-lookahead adder.
// Eight 4-bit groups; group generate/propagate form the inter-group carries,
// bit carries inside a group are expanded from the group carry-in.
module CLA (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [8:0] gc;
    logic [7:0] gg;
    logic [7:0] gp;

    assign gc[0] = cin;

    for (genvar k = 0; k < 8; k++) begin : g_grp
        logic [3:0] gi;
        logic [3:0] pi;
        logic [3:0] c;

        assign gi = a[4*k +: 4] & b[4*k +: 4];
        assign pi = a[4*k +: 4] ^ b[4*k +: 4];

        assign c[0] = gc[k];
        assign c[1] = gi[0] | (pi[0] & c[0]);
        assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c[0]);
        assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                    | (pi[2] & pi[1] & pi[0] & c[0]);

        assign sum[4*k +: 4] = pi ^ c;

        assign gg[k] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
                     | (pi[3] & pi[2] & pi[1] & gi[0]);
        assign gp[k] = &pi;
        assign gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end

    assign cout = gc[8];

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: streams wide-integer operand words (LS word first) through a
// 32-bit CLA, chaining the carry between words, with a one-stage registered
// valid/ready output.
// Optional feature macro: WIDE_ADD_SUB_EN enables A-B via B inversion and
// cin=1 on the first word; without it s_sub is ignored.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int IDX_W     = $clog2(MAX_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_a,
    input  logic [31:0]       s_b,
    input  logic              s_first,
    input  logic              s_last,
    input  logic              s_sub,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_sum,
    output logic [IDX_W-1:0]  m_idx,
    output logic              m_last,
    output logic              m_carry,
    output logic              m_ovf,
    output logic              m_err
);

    wa_state_e         state, state_nxt;
    logic              carry_q;
    logic [IDX_W-1:0]  idx_q;

    logic              accept;
    logic              is_first;
    logic              sub_eff;
    logic [WORD_W-1:0] b_eff;
    logic              cin;
    logic [WORD_W-1:0] sum;
    logic              cout;
    logic [IDX_W-1:0]  idx_nxt;
    logic              at_max;
    logic              last_eff;
    logic              err;
    logic              ovf;

    assign s_ready  = !m_valid || m_ready;
    assign accept   = s_valid && s_ready;

    // Any word arriving in IDLE starts an operation, flagged or not.
    assign is_first = s_first || (state == WA_IDLE);

`ifdef WIDE_ADD_SUB_EN
    logic sub_q;

    assign sub_eff = is_first ? s_sub : sub_q;
    assign b_eff   = s_b ^ {WORD_W{sub_eff}};

    // Operation type is fixed by its first word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sub_q <= 1'b0;
        else if (accept && is_first)
            sub_q <= s_sub;
    end
`else
    logic unused_sub;

    assign unused_sub = s_sub;
    assign sub_eff    = 1'b0;
    assign b_eff      = s_b;
`endif

    assign cin = is_first ? sub_eff : carry_q;

    CLA u_cla (
        .a    (s_a),
        .b    (b_eff),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    assign idx_nxt  = is_first ? '0 : idx_q + IDX_W'(1);
    assign at_max   = (idx_nxt == IDX_W'(MAX_WORDS - 1));
    // Running out of index space terminates the operation.
    assign last_eff = s_last || at_max;
    assign err      = (s_first && (state == WA_RUN))
                   || (!s_first && (state == WA_IDLE))
                   || (at_max && !s_last);
    assign ovf      = last_eff && (s_a[31] == b_eff[31]) && (sum[31] != s_a[31]);

    // Next-state: every accepted word decides IDLE/RUN by whether it ends the op.
    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = last_eff ? WA_IDLE : WA_RUN;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= WA_IDLE;
        else
            state <= state_nxt;
    end

    // Inter-word carry and word index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            carry_q <= cout;
            idx_q   <= idx_nxt;
        end
    end

    // Output stage: reloads on accept (even while draining), clears valid on a
    // drain with nothing new; data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_sum   <= '0;
            m_idx   <= '0;
            m_last  <= 1'b0;
            m_carry <= 1'b0;
            m_ovf   <= 1'b0;
            m_err   <= 1'b0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_sum   <= sum;
            m_idx   <= idx_nxt;
            m_last  <= last_eff;
            m_carry <= cout;
            m_ovf   <= ovf;
            m_err   <= err;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
